// File: rtl/rv32i_pkg.sv
// Shared types and encodings for the multi-cycle RV32I core.
package rv32i_pkg;

  typedef enum logic [1:0] {SFetch, SDecode, SExec, SLoad} state_t;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
  } alu_op_t;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam logic [2:0] F3_SB = 3'b000;
  localparam logic [2:0] F3_SH = 3'b001;
  localparam logic [2:0] F3_SW = 3'b010;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  // Map funct3 (plus the funct7 alternate bit) onto an ALU operation.
  function automatic alu_op_t alu_decode(input logic [2:0] f3, input logic alt);
    alu_op_t op;
    case (f3)
      F3_ADD:  op = alt ? ALU_SUB : ALU_ADD;
      F3_SLL:  op = ALU_SLL;
      F3_SLT:  op = ALU_SLT;
      F3_SLTU: op = ALU_SLTU;
      F3_XOR:  op = ALU_XOR;
      F3_SR:   op = alt ? ALU_SRA : ALU_SRL;
      F3_OR:   op = ALU_OR;
      F3_AND:  op = ALU_AND;
      default: op = ALU_ADD;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/rv32i_alu.sv
// Combinational RV32I ALU with branch comparison flags.
module rv32i_alu
  import rv32i_pkg::*;
(
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  alu_op_t     alu_op_i,
  output logic [31:0] result_o,
  output logic        eq_o,
  output logic        lt_o,
  output logic        ltu_o
);

  assign eq_o  = (a_i == b_i);
  assign lt_o  = ($signed(a_i) < $signed(b_i));
  assign ltu_o = (a_i < b_i);

  // Operation select; shift amounts use only the low five bits.
  always_comb begin
    result_o = '0;
    case (alu_op_i)
      ALU_ADD:  result_o = a_i + b_i;
      ALU_SUB:  result_o = a_i - b_i;
      ALU_SLL:  result_o = a_i << b_i[4:0];
      ALU_SLT:  result_o = {31'b0, lt_o};
      ALU_SLTU: result_o = {31'b0, ltu_o};
      ALU_XOR:  result_o = a_i ^ b_i;
      ALU_SRL:  result_o = a_i >> b_i[4:0];
      ALU_SRA:  result_o = 32'($signed(a_i) >>> b_i[4:0]);
      ALU_OR:   result_o = a_i | b_i;
      ALU_AND:  result_o = a_i & b_i;
      default:  result_o = '0;
    endcase
  end

endmodule

// File: rtl/rv32i_cpu.sv
// Multi-cycle RV32I core on a single synchronous-RAM bus.
// Optional: define RV32I_CPU_RV32E_EN for a 16-entry register file.
module rv32i_cpu
  import rv32i_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  output logic [29:0] bus_addr,
  input  logic [31:0] bus_data_r,
  output logic [31:0] bus_data_w,
  output logic [3:0]  bus_mask_w
);

`ifdef RV32I_CPU_RV32E_EN
  localparam int unsigned NREG = 16;
`else
  localparam int unsigned NREG = 32;
`endif
  localparam int unsigned RIDX_W = $clog2(NREG);

  state_t      state, state_d;
  logic [31:0] pc, pc_d;
  logic [31:0] inst, inst_d;
  logic [31:0] eff_q, eff_d;
  logic [31:0] regs [0:NREG-1];

  logic [6:0]        opcode;
  logic [2:0]        funct3;
  logic [RIDX_W-1:0] rs1_idx, rs2_idx, rd_idx;
  logic [31:0]       rs1_val, rs2_val;
  logic [31:0]       imm_i, imm_s, imm_b, imm_u, imm_j, pc_plus4;
  logic [31:0]       alu_a, alu_b, alu_res;
  alu_op_t           alu_op;
  logic              alu_eq, alu_lt, alu_ltu, br_taken;
  logic [3:0]        st_mask;
  logic [31:0]       st_data, load_val, rf_wdata;
  logic [7:0]        lane_b;
  logic [15:0]       lane_h;
  logic              rf_we;

  assign opcode  = inst[6:0];
  assign funct3  = inst[14:12];
  assign rd_idx  = inst[7 +: RIDX_W];
  assign rs1_idx = inst[15 +: RIDX_W];
  assign rs2_idx = inst[20 +: RIDX_W];
  assign rs1_val = (rs1_idx == '0) ? 32'd0 : regs[rs1_idx];
  assign rs2_val = (rs2_idx == '0) ? 32'd0 : regs[rs2_idx];

  assign imm_i    = {{20{inst[31]}}, inst[31:20]};
  assign imm_s    = {{20{inst[31]}}, inst[31:25], inst[11:7]};
  assign imm_b    = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
  assign imm_u    = {inst[31:12], 12'b0};
  assign imm_j    = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
  assign pc_plus4 = pc + 32'd4;

  // ALU operand and operation selection per opcode.
  always_comb begin
    alu_a  = rs1_val;
    alu_b  = rs2_val;
    alu_op = ALU_ADD;
    case (opcode)
      OP_AUIPC: begin
        alu_a = pc;
        alu_b = imm_u;
      end
      OP_JALR, OP_LOAD: alu_b = imm_i;
      OP_STORE: alu_b = imm_s;
      OP_IMM: begin
        alu_b  = imm_i;
        alu_op = alu_decode(funct3, inst[30] && (funct3 == F3_SR));
      end
      OP_OP: alu_op = alu_decode(funct3, inst[30]);
      default: ;
    endcase
  end

  rv32i_alu u_alu (
    .a_i      (alu_a),
    .b_i      (alu_b),
    .alu_op_i (alu_op),
    .result_o (alu_res),
    .eq_o     (alu_eq),
    .lt_o     (alu_lt),
    .ltu_o    (alu_ltu)
  );

  // Branch condition from the ALU compare flags.
  always_comb begin
    br_taken = 1'b0;
    case (funct3)
      F3_BEQ:  br_taken = alu_eq;
      F3_BNE:  br_taken = !alu_eq;
      F3_BLT:  br_taken = alu_lt;
      F3_BGE:  br_taken = !alu_lt;
      F3_BLTU: br_taken = alu_ltu;
      F3_BGEU: br_taken = !alu_ltu;
      default: br_taken = 1'b0;
    endcase
  end

  // Store lane enables and replicated write data.
  always_comb begin
    st_mask = 4'b0000;
    st_data = rs2_val;
    case (funct3)
      F3_SB: begin
        st_mask = 4'b0001 << alu_res[1:0];
        st_data = {4{rs2_val[7:0]}};
      end
      F3_SH: begin
        st_mask = alu_res[1] ? 4'b1100 : 4'b0011;
        st_data = {2{rs2_val[15:0]}};
      end
      F3_SW: st_mask = 4'b1111;
      default: ;
    endcase
  end

  // Load lane extraction and sign/zero extension.
  always_comb begin
    lane_b   = bus_data_r[{eff_q[1:0], 3'b000} +: 8];
    lane_h   = eff_q[1] ? bus_data_r[31:16] : bus_data_r[15:0];
    load_val = bus_data_r;
    case (funct3)
      F3_LB:   load_val = {{24{lane_b[7]}}, lane_b};
      F3_LH:   load_val = {{16{lane_h[15]}}, lane_h};
      F3_LW:   load_val = bus_data_r;
      F3_LBU:  load_val = {24'b0, lane_b};
      F3_LHU:  load_val = {16'b0, lane_h};
      default: load_val = bus_data_r;
    endcase
  end

  // Next-state, bus drive and write-back selection.
  always_comb begin
    state_d    = state;
    pc_d       = pc;
    inst_d     = inst;
    eff_d      = eff_q;
    bus_addr   = pc[31:2];
    bus_data_w = rs2_val;
    bus_mask_w = 4'b0000;
    rf_we      = 1'b0;
    rf_wdata   = alu_res;
    case (state)
      SFetch: state_d = SDecode;
      SDecode: begin
        inst_d  = bus_data_r;
        state_d = SExec;
      end
      SExec: begin
        state_d = SFetch;
        pc_d    = pc_plus4;
        eff_d   = alu_res;
        case (opcode)
          OP_LUI: begin
            rf_we    = 1'b1;
            rf_wdata = imm_u;
          end
          OP_AUIPC, OP_IMM, OP_OP: rf_we = 1'b1;
          OP_JAL: begin
            rf_we    = 1'b1;
            rf_wdata = pc_plus4;
            pc_d     = pc + imm_j;
          end
          OP_JALR: begin
            rf_we    = 1'b1;
            rf_wdata = pc_plus4;
            pc_d     = alu_res & ~32'd1;
          end
          OP_BRANCH: if (br_taken) pc_d = pc + imm_b;
          OP_LOAD: begin
            bus_addr = alu_res[31:2];
            state_d  = SLoad;
          end
          OP_STORE: begin
            bus_addr   = alu_res[31:2];
            bus_data_w = st_data;
            bus_mask_w = st_mask;
          end
          default: ;
        endcase
      end
      SLoad: begin
        bus_addr = eff_q[31:2];
        rf_we    = 1'b1;
        rf_wdata = load_val;
        state_d  = SFetch;
      end
      default: state_d = SFetch;
    endcase
    if (!reset) bus_mask_w = 4'b0000;
  end

  // Control state register; reset abandons any in-flight instruction.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= SFetch;
      pc    <= RESET_PC;
      inst  <= '0;
      eff_q <= '0;
    end else begin
      state <= state_d;
      pc    <= pc_d;
      inst  <= inst_d;
      eff_q <= eff_d;
    end
  end

  // Register file write port; x0 writes are dropped.
  always_ff @(posedge clock) begin
    if (rf_we && (rd_idx != '0)) regs[rd_idx] <= rf_wdata;
  end

endmodule

// File: tb/tb_rv32i_cpu.sv
// Bench for rv32i_cpu: block-RAM model, store scoreboard, per-feature program tasks.
module tb_rv32i_cpu;
  import rv32i_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [29:0] bus_addr;
  logic [31:0] bus_data_r, bus_data_w;
  logic [3:0]  bus_mask_w;

  rv32i_cpu #(.RESET_PC(32'h0000_0000)) dut (
    .clock      (clk),
    .reset      (rst_n),
    .bus_addr   (bus_addr),
    .bus_data_r (bus_data_r),
    .bus_data_w (bus_data_w),
    .bus_mask_w (bus_mask_w)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [0:255];
  logic [31:0] img [0:255];
  logic        load_en;

  // Synchronous RAM: one-cycle read latency, byte-masked writes, image load.
  always @(posedge clk) begin
    if (load_en) begin
      for (int i = 0; i < 256; i++) mem[i] <= img[i];
    end else begin
      for (int b = 0; b < 4; b++)
        if (bus_mask_w[b]) mem[bus_addr[7:0]][8*b +: 8] <= bus_data_w[8*b +: 8];
      bus_data_r <= mem[bus_addr[7:0]];
    end
  end

  typedef struct packed {
    logic [29:0] addr;
    logic [31:0] data;
    logic [3:0]  mask;
  } st_t;

  st_t exp_q[$];
  int  total = 0;
  int  bad = 0;

  localparam logic [6:0] O_IMM = 7'b0010011;
  localparam logic [31:0] ECALL = 32'h0000_0073;

  function automatic logic [31:0] i_t(int imm, int rs1, logic [2:0] f3, int rd, logic [6:0] op);
    logic [11:0] im;
    im = 12'(imm);
    return {im, 5'(rs1), f3, 5'(rd), op};
  endfunction

  function automatic logic [31:0] r_t(logic [6:0] f7, int rs2, int rs1, logic [2:0] f3, int rd);
    return {f7, 5'(rs2), 5'(rs1), f3, 5'(rd), 7'b0110011};
  endfunction

  function automatic logic [31:0] s_t(int imm, int rs2, int rs1, logic [2:0] f3);
    logic [11:0] im;
    im = 12'(imm);
    return {im[11:5], 5'(rs2), 5'(rs1), f3, im[4:0], 7'b0100011};
  endfunction

  function automatic logic [31:0] b_t(int imm, int rs2, int rs1, logic [2:0] f3);
    logic [12:0] im;
    im = 13'(imm);
    return {im[12], im[10:5], 5'(rs2), 5'(rs1), f3, im[4:1], im[11], 7'b1100011};
  endfunction

  function automatic logic [31:0] u_t(int imm20, int rd, logic [6:0] op);
    return {20'(imm20), 5'(rd), op};
  endfunction

  function automatic logic [31:0] j_t(int imm, int rd);
    logic [20:0] im;
    im = 21'(imm);
    return {im[20], im[10:1], im[11], im[19:12], 5'(rd), 7'b1101111};
  endfunction

  task automatic clear_img();
    for (int i = 0; i < 256; i++) img[i] = 32'h0;
  endtask

  task automatic apply_reset();
    rst_n   = 1'b0;
    load_en = 1'b1;
    repeat (2) @(negedge clk);
    load_en = 1'b0;
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Step the core until it executes ECALL, scoring every store against the queue.
  task automatic run_prog(input int budget, output int cyc);
    st_t e;
    cyc = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (bus_mask_w != 4'b0000) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL store_unexpected got addr=%h data=%h mask=%b", bus_addr, bus_data_w, bus_mask_w);
        end else begin
          e = exp_q.pop_front();
          if ({bus_addr, bus_data_w, bus_mask_w} !== e) begin
            bad++;
            $display("FAIL store_sb got addr=%h data=%h mask=%b want addr=%h data=%h mask=%b",
                     bus_addr, bus_data_w, bus_mask_w, e.addr, e.data, e.mask);
          end
        end
      end
      if (dut.state == SExec && dut.inst[31:2] == 30'b11100) break;
      if (cyc >= budget) begin
        total++;
        bad++;
        $display("FAIL run_timeout cycles=%0d want ecall within %0d", cyc, budget);
        break;
      end
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL store_missing pending=%0d want 0", exp_q.size());
    end
  endtask

  task automatic fill_arith();
    clear_img();
    img[0]  = i_t(-1, 0, 3'b000, 10, O_IMM);
    img[1]  = r_t(7'b0, 10, 10, 3'b000, 11);
    img[2]  = i_t(5, 0, 3'b000, 0, O_IMM);
    img[3]  = r_t(7'b0, 0, 0, 3'b000, 15);
    img[4]  = u_t(32'h80000, 5, 7'b0110111);
    img[5]  = i_t(32'h41F, 5, 3'b101, 6, O_IMM);
    img[6]  = i_t(31, 5, 3'b101, 7, O_IMM);
    img[7]  = i_t(0, 10, 3'b010, 8, O_IMM);
    img[8]  = i_t(0, 10, 3'b011, 9, O_IMM);
    img[9]  = r_t(7'b0100000, 11, 0, 3'b000, 12);
    img[10] = i_t(32'hF, 11, 3'b100, 13, O_IMM);
    img[11] = u_t(1, 14, 7'b0010111);
    img[12] = ECALL;
  endtask

  task automatic test_reset();
    fill_arith();
    rst_n   = 1'b0;
    load_en = 1'b1;
    @(negedge clk);
    @(negedge clk);
    total++;
    if (bus_mask_w !== 4'b0000 || dut.pc !== 32'h0 || dut.state !== SFetch || dut.inst !== 32'h0) begin
      bad++;
      $display("FAIL in_reset got mask=%b pc=%h state=%0d inst=%h want 0000/0/SFetch/0",
               bus_mask_w, dut.pc, dut.state, dut.inst);
    end
    load_en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    total++;
    if (bus_addr !== 30'h0 || bus_mask_w !== 4'b0000) begin
      bad++;
      $display("FAIL first_cycle got addr=%h mask=%b want 0/0000", bus_addr, bus_mask_w);
    end
    @(negedge clk);
    @(negedge clk);
    total++;
    if (dut.state !== SExec || dut.inst !== img[0]) begin
      bad++;
      $display("FAIL third_cycle got state=%0d inst=%h want SExec/%h", dut.state, dut.inst, img[0]);
    end
  endtask

  task automatic test_arith();
    int ri [11] = '{10, 11, 15, 5, 6, 7, 8, 9, 12, 13, 14};
    logic [31:0] rv [11] = '{32'hFFFFFFFF, 32'hFFFFFFFE, 32'h0, 32'h80000000, 32'hFFFFFFFF,
                             32'h1, 32'h1, 32'h0, 32'h2, 32'hFFFFFFF1, 32'h0000102C};
    int cyc;
    fill_arith();
    apply_reset();
    run_prog(200, cyc);
    total++;
    if (cyc != 38) begin
      bad++;
      $display("FAIL arith_cycles got %0d want 38", cyc);
    end
    for (int k = 0; k < 11; k++) begin
      total++;
      if (dut.regs[ri[k]] !== rv[k]) begin
        bad++;
        $display("FAIL arith_x%0d got %h want %h", ri[k], dut.regs[ri[k]], rv[k]);
      end
    end
  endtask

  task automatic test_mem();
    int ri [6] = '{4, 5, 6, 7, 8, 9};
    logic [31:0] rv [6] = '{32'hFFFFFFAA, 32'h000000AA, 32'h1234AA78, 32'h00005678,
                            32'h00005678, 32'hAA000000};
    int cyc;
    clear_img();
    img[0]  = u_t(32'h12345, 1, 7'b0110111);
    img[1]  = i_t(32'h678, 1, 3'b000, 1, O_IMM);
    img[2]  = i_t(32'h100, 0, 3'b000, 2, O_IMM);
    img[3]  = s_t(0, 1, 2, 3'b010);
    img[4]  = i_t(32'hAA, 0, 3'b000, 3, O_IMM);
    img[5]  = s_t(1, 3, 2, 3'b000);
    img[6]  = i_t(1, 2, 3'b000, 4, 7'b0000011);
    img[7]  = i_t(1, 2, 3'b100, 5, 7'b0000011);
    img[8]  = i_t(0, 2, 3'b010, 6, 7'b0000011);
    img[9]  = s_t(2, 1, 2, 3'b001);
    img[10] = i_t(2, 2, 3'b001, 7, 7'b0000011);
    img[11] = i_t(3, 2, 3'b101, 8, 7'b0000011);
    img[12] = s_t(7, 3, 2, 3'b000);
    img[13] = i_t(4, 2, 3'b010, 9, 7'b0000011);
    img[14] = ECALL;
    apply_reset();
    exp_q.push_back('{addr: 30'h40, data: 32'h12345678, mask: 4'b1111});
    exp_q.push_back('{addr: 30'h40, data: 32'hAAAAAAAA, mask: 4'b0010});
    exp_q.push_back('{addr: 30'h40, data: 32'h56785678, mask: 4'b1100});
    exp_q.push_back('{addr: 30'h41, data: 32'hAAAAAAAA, mask: 4'b1000});
    run_prog(300, cyc);
    total++;
    if (cyc != 50) begin
      bad++;
      $display("FAIL mem_cycles got %0d want 50", cyc);
    end
    for (int k = 0; k < 6; k++) begin
      total++;
      if (dut.regs[ri[k]] !== rv[k]) begin
        bad++;
        $display("FAIL mem_x%0d got %h want %h", ri[k], dut.regs[ri[k]], rv[k]);
      end
    end
    total++;
    if (mem[64] !== 32'h5678AA78 || mem[65] !== 32'hAA000000) begin
      bad++;
      $display("FAIL mem_image got %h %h want 5678aa78 aa000000", mem[64], mem[65]);
    end
  endtask

  task automatic test_branch();
    int cyc;
    clear_img();
    img[0]  = i_t(0, 0, 3'b000, 10, O_IMM);
    img[1]  = i_t(1, 0, 3'b000, 1, O_IMM);
    img[2]  = i_t(-1, 0, 3'b000, 2, O_IMM);
    img[3]  = b_t(8, 1, 1, 3'b000);
    img[4]  = i_t(1, 0, 3'b000, 10, O_IMM);
    img[5]  = b_t(8, 2, 1, 3'b000);
    img[6]  = j_t(8, 0);
    img[7]  = i_t(2, 0, 3'b000, 10, O_IMM);
    img[8]  = b_t(8, 1, 2, 3'b100);
    img[9]  = i_t(3, 0, 3'b000, 10, O_IMM);
    img[10] = b_t(8, 1, 2, 3'b110);
    img[11] = j_t(8, 0);
    img[12] = i_t(4, 0, 3'b000, 10, O_IMM);
    img[13] = i_t(32'h42, 0, 3'b000, 1, O_IMM);
    img[14] = i_t(3, 1, 3'b000, 1, 7'b1100111);
    img[15] = i_t(5, 0, 3'b000, 10, O_IMM);
    img[16] = i_t(6, 0, 3'b000, 10, O_IMM);
    img[17] = ECALL;
    apply_reset();
    run_prog(200, cyc);
    total++;
    if (cyc != 35) begin
      bad++;
      $display("FAIL branch_cycles got %0d want 35", cyc);
    end
    total++;
    if (dut.pc !== 32'h44) begin
      bad++;
      $display("FAIL branch_ecall_pc got %h want 00000044", dut.pc);
    end
    total++;
    if (dut.regs[10] !== 32'h0) begin
      bad++;
      $display("FAIL branch_x10 got %h want 00000000", dut.regs[10]);
    end
    total++;
    if (dut.regs[1] !== 32'h3C) begin
      bad++;
      $display("FAIL jalr_link got %h want 0000003c", dut.regs[1]);
    end
  endtask

  task automatic test_reset_mid_store();
    int n;
    clear_img();
    img[0] = i_t(32'h55, 0, 3'b000, 1, O_IMM);
    img[1] = s_t(32'h80, 1, 0, 3'b010);
    img[2] = ECALL;
    apply_reset();
    n = 0;
    while (bus_mask_w == 4'b0000 && n < 20) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (bus_addr !== 30'h20 || bus_mask_w !== 4'b1111 || bus_data_w !== 32'h55) begin
      bad++;
      $display("FAIL pending_store got addr=%h data=%h mask=%b want 20/00000055/1111",
               bus_addr, bus_data_w, bus_mask_w);
    end
    rst_n = 1'b0;
    #1;
    total++;
    if (bus_mask_w !== 4'b0000 || dut.state !== SFetch || dut.pc !== 32'h0) begin
      bad++;
      $display("FAIL reset_abort got mask=%b state=%0d pc=%h want 0000/SFetch/0",
               bus_mask_w, dut.state, dut.pc);
    end
    repeat (2) @(negedge clk);
    total++;
    if (mem[32] !== 32'h0) begin
      bad++;
      $display("FAIL reset_store_dropped got mem=%h want 00000000", mem[32]);
    end
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n   = 1'b0;
    load_en = 1'b0;
    test_reset();
    test_arith();
    test_mem();
    test_branch();
    test_reset_mid_store();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
